// File: rtl/pipelined_carry_select_adder_pkg.sv
// Shared helpers for the pipelined carry-select adder: stage count and geometry check.
package pipelined_carry_select_adder_pkg;

  // Number of BLOCK-bit segments (and therefore pipeline stages) for a given width.
  function automatic int nb(input int width, input int block);
    return (block > 0) ? (width / block) : 1;
  endfunction

  function automatic bit width_ok(input int width, input int block);
    return (block > 0) && (width >= block) && ((width % block) == 0);
  endfunction

endpackage

// File: rtl/pipelined_carry_select_adder_block.sv
// One carry-select segment: both carry hypotheses are summed, the incoming carry picks one.
// With PCSA_OVF_EN defined it also reports the carry into its top bit.
module pipelined_carry_select_adder_block #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] i_a,
  input  logic [BLOCK-1:0] i_b,
  input  logic             i_ci,
  output logic [BLOCK-1:0] o_s,
  output logic             o_co
`ifdef PCSA_OVF_EN
  ,
  output logic             o_c_top
`endif
);

  localparam logic [BLOCK:0] ONE = {{BLOCK{1'b0}}, 1'b1};

  logic [BLOCK:0] w_sum0;
  logic [BLOCK:0] w_sum1;

  assign w_sum0 = {1'b0, i_a} + {1'b0, i_b};
  assign w_sum1 = {1'b0, i_a} + {1'b0, i_b} + ONE;
  assign {o_co, o_s} = i_ci ? w_sum1 : w_sum0;

`ifdef PCSA_OVF_EN
  // The carry into the top bit falls out of the top sum bit and its two addend bits.
  assign o_c_top = o_s[BLOCK-1] ^ i_a[BLOCK-1] ^ i_b[BLOCK-1];
`endif

endmodule

// File: rtl/pipelined_carry_select_adder.sv
// Pipelined add/subtract unit: one carry-select segment per stage, valid/ready on both sides.
// Optional signed-overflow output is enabled by defining PCSA_OVF_EN.
module pipelined_carry_select_adder
  import pipelined_carry_select_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PCSA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NB = nb(WIDTH, BLOCK);

  typedef struct packed {
    logic             carry;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef PCSA_OVF_EN
    logic             ovf;
`endif
  } payload_t;

  if (!width_ok(WIDTH, BLOCK)) begin : g_bad_geometry
    $error("pipelined_carry_select_adder: WIDTH (%0d) must be a positive multiple of BLOCK (%0d)",
           WIDTH, BLOCK);
  end

  // Index s is the payload entering stage s; index s+1 is what stage s holds.
  payload_t [NB:0] w_pl_in;
  logic     [NB:0] w_v_in;
  logic     [NB:0] w_rdy;
  payload_t        w_head;
  logic            w_unused_tail;

  always_comb begin
    w_head       = '0;
    w_head.a     = a;
    w_head.b     = b ^ {WIDTH{sub}};
    w_head.carry = cin ^ sub;
  end

  assign w_pl_in[0] = w_head;
  assign w_v_in[0]  = in_valid;
  assign w_rdy[NB]  = out_ready;
  assign in_ready   = w_rdy[0];

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_stage
      payload_t         r_pl;
      logic             r_valid;
      payload_t         w_nx;
      logic [BLOCK-1:0] w_seg;
      logic             w_co;
`ifdef PCSA_OVF_EN
      logic             w_ctop;
`endif

      // A stage may take new data when empty or when its own content moves on this cycle.
      assign w_rdy[gi] = !r_valid || w_rdy[gi+1];

      pipelined_carry_select_adder_block #(.BLOCK(BLOCK)) u_seg (
        .i_a     (w_pl_in[gi].a[gi*BLOCK +: BLOCK]),
        .i_b     (w_pl_in[gi].b[gi*BLOCK +: BLOCK]),
        .i_ci    (w_pl_in[gi].carry),
        .o_s     (w_seg),
        .o_co    (w_co)
`ifdef PCSA_OVF_EN
        ,
        .o_c_top (w_ctop)
`endif
      );

      always_comb begin
        w_nx                       = w_pl_in[gi];
        w_nx.carry                 = w_co;
        w_nx.sum[gi*BLOCK +: BLOCK] = w_seg;
`ifdef PCSA_OVF_EN
        w_nx.ovf = (gi == NB - 1) ? (w_ctop ^ w_co) : w_pl_in[gi].ovf;
`endif
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_valid <= 1'b0;
          r_pl    <= '0;
        end else if (w_rdy[gi]) begin
          r_valid <= w_v_in[gi];
          if (w_v_in[gi]) begin
            r_pl <= w_nx;
          end
        end
      end

      assign w_pl_in[gi+1] = r_pl;
      assign w_v_in[gi+1]  = r_valid;
    end
  endgenerate

  assign out_valid = w_v_in[NB];
  assign sum       = w_pl_in[NB].sum;
  assign cout      = w_pl_in[NB].carry;
`ifdef PCSA_OVF_EN
  assign ovf       = w_pl_in[NB].ovf;
`endif

  // Operands are fully consumed by the last segment; nothing downstream needs them.
  assign w_unused_tail = ^{w_pl_in[NB].a, w_pl_in[NB].b};

endmodule

// File: tb/tb_pipelined_carry_select_adder.sv
// Self-checking bench: directed vectors on an 8/4 unit, stall and reset sequences,
// and random backpressured streams on 16/4 and 16/16 units.
module tb_pipelined_carry_select_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       m_in_valid, m_in_ready, m_cin, m_sub, m_out_valid, m_out_ready, m_cout;
  logic [7:0] m_a, m_b, m_sum;
  logic       m_ovf;

  logic        rv_in_valid [2];
  logic        rv_in_ready [2];
  logic        rv_cin [2];
  logic        rv_sub [2];
  logic        rv_out_valid [2];
  logic        rv_out_ready [2];
  logic        rv_cout [2];
  logic        rv_ovf [2];
  logic [15:0] rv_a [2];
  logic [15:0] rv_b [2];
  logic [15:0] rv_sum [2];

  int checks = 0;
  int errors = 0;

  pipelined_carry_select_adder #(.WIDTH(8), .BLOCK(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(m_in_valid), .in_ready(m_in_ready),
    .a(m_a), .b(m_b), .cin(m_cin), .sub(m_sub),
    .out_valid(m_out_valid), .out_ready(m_out_ready), .sum(m_sum), .cout(m_cout)
`ifdef PCSA_OVF_EN
    , .ovf(m_ovf)
`endif
  );

  pipelined_carry_select_adder #(.WIDTH(16), .BLOCK(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(rv_in_valid[0]), .in_ready(rv_in_ready[0]),
    .a(rv_a[0]), .b(rv_b[0]), .cin(rv_cin[0]), .sub(rv_sub[0]),
    .out_valid(rv_out_valid[0]), .out_ready(rv_out_ready[0]), .sum(rv_sum[0]), .cout(rv_cout[0])
`ifdef PCSA_OVF_EN
    , .ovf(rv_ovf[0])
`endif
  );

  pipelined_carry_select_adder #(.WIDTH(16), .BLOCK(16)) u_dut1s (
    .clk(clk), .rst_n(rst_n), .in_valid(rv_in_valid[1]), .in_ready(rv_in_ready[1]),
    .a(rv_a[1]), .b(rv_b[1]), .cin(rv_cin[1]), .sub(rv_sub[1]),
    .out_valid(rv_out_valid[1]), .out_ready(rv_out_ready[1]), .sum(rv_sum[1]), .cout(rv_cout[1])
`ifdef PCSA_OVF_EN
    , .ovf(rv_ovf[1])
`endif
  );

`ifndef PCSA_OVF_EN
  assign m_ovf     = 1'b0;
  assign rv_ovf[0] = 1'b0;
  assign rv_ovf[1] = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    string      name;
  } vec_t;

  vec_t vecs [13];

  // Random stream for the 16-bit units: independent model, scoreboard queue, random backpressure.
  task automatic rand_stream(input int k, input int nbeats);
    logic [16:0] expq [$];
    logic        ovfq [$];
    logic [16:0] full;
    logic [15:0] pa, pb, beff;
    logic        pc, ps, eo;
    int          sent = 0;
    int          got  = 0;
    int          cyc  = 0;
    pa = 16'($urandom); pb = 16'($urandom); pc = 1'($urandom); ps = 1'($urandom);
    while (got < nbeats && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      rv_out_ready[k] = ($urandom_range(0, 3) != 0);
      rv_in_valid[k]  = (sent < nbeats) && ($urandom_range(0, 4) != 0);
      rv_a[k] = pa; rv_b[k] = pb; rv_cin[k] = pc; rv_sub[k] = ps;
      #1;
      if (rv_out_valid[k] && rv_out_ready[k]) begin
        if (expq.size() == 0) begin
          check($sformatf("rand%0d_spurious_beat", k), 32'd1, 32'd0);
        end else begin
          full = expq.pop_front();
          eo   = ovfq.pop_front();
          check($sformatf("rand%0d_result", k), {15'd0, rv_cout[k], rv_sum[k]}, {15'd0, full});
`ifdef PCSA_OVF_EN
          check($sformatf("rand%0d_ovf", k), {31'd0, rv_ovf[k]}, {31'd0, eo});
`endif
        end
        got++;
      end
      if (rv_in_valid[k] && rv_in_ready[k]) begin
        beff = ps ? ~pb : pb;
        full = {1'b0, pa} + {1'b0, beff} + {16'd0, pc ^ ps};
        eo   = (pa[15] == beff[15]) && (full[15] != pa[15]);
        expq.push_back(full);
        ovfq.push_back(eo);
        sent++;
        pa = 16'($urandom); pb = 16'($urandom); pc = 1'($urandom); ps = 1'($urandom);
      end
    end
    @(negedge clk);
    rv_in_valid[k] = 1'b0;
    check($sformatf("rand%0d_beats_drained", k), got, nbeats);
    $display("rand stream %0d: %0d beats sent, %0d received in %0d cycles", k, sent, got, cyc);
  endtask

  initial begin
    vecs[0]  = '{8'd100, 8'd50,  1'b0, 1'b0, 8'd150, 1'b0, 1'b1, "add_100_50"};
    vecs[1]  = '{8'd200, 8'd100, 1'b1, 1'b0, 8'd45,  1'b1, 1'b0, "add_200_100_c1"};
    vecs[2]  = '{8'hFF,  8'h01,  1'b0, 1'b0, 8'h00,  1'b1, 1'b0, "add_ff_01"};
    vecs[3]  = '{8'd50,  8'd100, 1'b0, 1'b1, 8'd206, 1'b0, 1'b0, "sub_50_100"};
    vecs[4]  = '{8'd100, 8'd50,  1'b0, 1'b1, 8'd50,  1'b1, 1'b0, "sub_100_50"};
    vecs[5]  = '{8'd0,   8'd0,   1'b1, 1'b0, 8'd1,   1'b0, 1'b0, "add_0_0_c1"};
    vecs[6]  = '{8'd10,  8'd3,   1'b1, 1'b1, 8'd6,   1'b1, 1'b0, "sub_10_3_c1"};
    vecs[7]  = '{8'h0F,  8'h01,  1'b0, 1'b0, 8'h10,  1'b0, 1'b0, "add_0f_01"};
    vecs[8]  = '{8'hFF,  8'hFF,  1'b1, 1'b0, 8'hFF,  1'b1, 1'b0, "add_ff_ff_c1"};
    vecs[9]  = '{8'd0,   8'd0,   1'b0, 1'b1, 8'd0,   1'b1, 1'b0, "sub_0_0"};
    vecs[10] = '{8'd127, 8'd1,   1'b0, 1'b0, 8'h80,  1'b0, 1'b1, "add_127_1"};
    vecs[11] = '{8'h80,  8'h01,  1'b0, 1'b1, 8'h7F,  1'b1, 1'b1, "sub_80_01"};
    vecs[12] = '{8'd5,   8'd3,   1'b0, 1'b0, 8'd8,   1'b0, 1'b0, "add_5_3"};

    rst_n = 1'b0;
    m_in_valid = 1'b0; m_out_ready = 1'b1; m_a = '0; m_b = '0; m_cin = 1'b0; m_sub = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rv_in_valid[k] = 1'b0; rv_out_ready[k] = 1'b1;
      rv_a[k] = '0; rv_b[k] = '0; rv_cin[k] = 1'b0; rv_sub[k] = 1'b0;
    end
    repeat (2) @(negedge clk);
    check("reset_out_valid", {31'd0, m_out_valid}, 32'd0);
    check("reset_sum", {24'd0, m_sum}, 32'd0);
    check("reset_cout", {31'd0, m_cout}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("post_reset_in_ready", {31'd0, m_in_ready}, 32'd1);

    // Directed vectors: present at a negedge, accepted at the next rising edge (edge 0);
    // NB=2, so out_valid is low after edge 0 and high after edge 1.
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      m_a = vecs[i].a; m_b = vecs[i].b; m_cin = vecs[i].cin; m_sub = vecs[i].sub;
      m_in_valid = 1'b1; m_out_ready = 1'b1;
      #1;
      check({vecs[i].name, "_in_ready"}, {31'd0, m_in_ready}, 32'd1);
      @(negedge clk);
      m_in_valid = 1'b0;
      #1;
      check({vecs[i].name, "_not_early"}, {31'd0, m_out_valid}, 32'd0);
      @(negedge clk);
      #1;
      check({vecs[i].name, "_out_valid"}, {31'd0, m_out_valid}, 32'd1);
      check({vecs[i].name, "_sum"}, {24'd0, m_sum}, {24'd0, vecs[i].sum});
      check({vecs[i].name, "_cout"}, {31'd0, m_cout}, {31'd0, vecs[i].cout});
`ifdef PCSA_OVF_EN
      check({vecs[i].name, "_ovf"}, {31'd0, m_ovf}, {31'd0, vecs[i].ovf});
`endif
      $display("vec %s: %0d op %0d cin=%0d sub=%0d -> sum=%0d cout=%0d",
               vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, m_sum, m_cout);
    end
    @(negedge clk);

    // Back-to-back beats under a 4-cycle output stall.
    begin
      logic [7:0] src_a [3];
      logic [7:0] src_b [3];
      logic [7:0] exp_s [3];
      int idx = 0;
      int got = 0;
      src_a = '{8'd10, 8'd20, 8'd30};
      src_b = '{8'd1, 8'd2, 8'd3};
      exp_s = '{8'd11, 8'd22, 8'd33};
      m_cin = 1'b0; m_sub = 1'b0;
      for (int cyc = 0; cyc < 20 && got < 3; cyc++) begin
        if (cyc > 0) @(negedge clk);
        m_out_ready = (cyc >= 4);
        m_in_valid  = (idx < 3);
        m_a = (idx < 3) ? src_a[idx] : 8'd0;
        m_b = (idx < 3) ? src_b[idx] : 8'd0;
        #1;
        if (cyc == 2) check("stall_in_ready_low_when_full", {31'd0, m_in_ready}, 32'd0);
        if (cyc == 2 || cyc == 3) begin
          check("stall_out_valid_held", {31'd0, m_out_valid}, 32'd1);
          check("stall_sum_stable", {24'd0, m_sum}, 32'd11);
        end
        if (m_out_valid && m_out_ready) begin
          check($sformatf("stream_beat%0d_sum", got), {24'd0, m_sum}, {24'd0, exp_s[got]});
          $display("stream beat %0d: sum=%0d", got, m_sum);
          got++;
        end
        if (m_in_valid && m_in_ready) idx++;
      end
      check("stream_beats_received", got, 3);
      m_in_valid = 1'b0;
      repeat (2) begin
        @(negedge clk);
        #1;
        check("stream_no_duplicate", {31'd0, m_out_valid}, 32'd0);
      end
    end

    // Asynchronous reset with two beats in flight.
    @(negedge clk);
    m_out_ready = 1'b0; m_in_valid = 1'b1; m_a = 8'd7; m_b = 8'd8; m_sub = 1'b0; m_cin = 1'b0;
    @(negedge clk);
    m_a = 8'd9; m_b = 8'd9;
    @(negedge clk);
    m_in_valid = 1'b0;
    #1;
    check("inflight_out_valid_before_reset", {31'd0, m_out_valid}, 32'd1);
    check("inflight_sum_before_reset", {24'd0, m_sum}, 32'd15);
    rst_n = 1'b0;
    #1;
    check("async_reset_out_valid", {31'd0, m_out_valid}, 32'd0);
    check("async_reset_sum", {24'd0, m_sum}, 32'd0);
    check("async_reset_cout", {31'd0, m_cout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_out_ready = 1'b1;
    #1;
    check("after_reset_in_ready", {31'd0, m_in_ready}, 32'd1);
    repeat (4) begin
      @(negedge clk);
      #1;
      check("no_stale_beat", {31'd0, m_out_valid}, 32'd0);
    end
    $display("reset sequence: done");

    fork
      rand_stream(0, 200);
      rand_stream(1, 200);
    join

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
